// File: rtl/be_serial_add_if.sv
// Handshake and result bundle for the bit-serial adder.
// master = requester (drives start/operands), slave = adder.
interface be_serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic [1:0]       state;   // FSM state for observation: 0=IDLE 1=RUN 2=DONE

    // Handshake: start is accepted on a rising edge only while the adder is
    // IDLE or DONE (busy=0); a/b/ci are captured on that edge. start while
    // busy=1 is dropped. done pulses one cycle when sum/co take the new result.
    modport master (
        output start, a, b, ci,
        input  busy, done, sum, co, state
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, sum, co, state
    );
endinterface

// File: rtl/be_serial_add.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock. {co,sum} = a + b + ci after WIDTH RUN cycles.
module be_serial_add #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    be_serial_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;

    logic             s;
    logic             c_next;
    logic             last;
    logic             load;

    // Single full-adder cell on the current LSBs.
    assign s      = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign load   = bus.start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
        bus.state = state;
        bus.sum   = sum_q;
        bus.co    = co_q;
    end

    // Operand shifters, carry, bit counter and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            c    <= bus.ci;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c    <= c_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum_q <= acc_next;
                co_q  <= c_next;
            end
        end
    end

    // Sum bits enter at the MSB and walk down, so after WIDTH shifts
    // bit 0 of the accumulator holds the first (LSB) sum bit.
    generate
        if (WIDTH > 1) begin : g_acc
            logic [WIDTH-1:0] acc;

            assign acc_next = {s, acc[WIDTH-1:1]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (load) begin
                    acc <= '0;
                end else if (state == RUN) begin
                    acc <= acc_next;
                end
            end
        end else begin : g_acc1
            assign acc_next = s;
        end
    endgenerate
endmodule

// File: tb/tb_be_serial_add.sv
// Directed bench for be_serial_add: WIDTH=8 instance for the arithmetic,
// timing, ignore/back-to-back/reset cases, WIDTH=1 instance for the FA table.
module tb_be_serial_add;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;
    int n_fail;

    be_serial_add_if #(.WIDTH(8)) bus8 ();
    be_serial_add_if #(.WIDTH(1)) bus1 ();

    be_serial_add #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    be_serial_add #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every drive and every sample happens 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full 8-bit add: start edge, 8 busy cycles, done pulse, back to IDLE.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] exp_sum, input logic exp_co);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.ci    = ci;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, " busy"}, 32'(bus8.busy), 32'd1);
            check({tag, " no_done"}, 32'(bus8.done), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(bus8.done), 32'd1);
        check({tag, " busy_low"}, 32'(bus8.busy), 32'd0);
        check({tag, " sum"}, 32'(bus8.sum), 32'(exp_sum));
        check({tag, " co"}, 32'(bus8.co), 32'(exp_co));
        tick();
        check({tag, " done_1cyc"}, 32'(bus8.done), 32'd0);
        check({tag, " idle"}, 32'(bus8.state), 32'd0);
    endtask

    // Full-adder truth table indexed by {a,b,ci}, value {co,sum}.
    logic [1:0] fa_tab [8];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        fa_tab   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.ci    = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.ci    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst sum", 32'(bus8.sum), 32'd0);
        check("rst co", 32'(bus8.co), 32'd0);
        check("rst state", 32'(bus8.state), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle no start", 32'(bus8.busy), 32'd0);

        // Basic adds
        run8("t1 00+00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run8("t2 ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("t2 3c+0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        run8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run8("3c+0f again", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // Start during RUN is ignored; sum holds across the accepted start
        bus8.start = 1'b1;
        bus8.a     = 8'hA5;
        bus8.b     = 8'h5A;
        bus8.ci    = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("t3 sum held on start", 32'(bus8.sum), 32'h4B);
        tick();
        tick();
        bus8.start = 1'b1;
        bus8.a     = 8'h11;
        bus8.b     = 8'h00;
        bus8.ci    = 1'b0;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t3 done", 32'(bus8.done), 32'd1);
        check("t3 sum", 32'(bus8.sum), 32'h00);
        check("t3 co", 32'(bus8.co), 32'd1);
        tick();
        check("t3 idle after", 32'(bus8.state), 32'd0);
        check("t3 sum stays", 32'(bus8.sum), 32'h00);
        check("t3 co stays", 32'(bus8.co), 32'd1);

        // Back-to-back: start held through the done cycle
        bus8.start = 1'b1;
        bus8.a     = 8'h7F;
        bus8.b     = 8'h01;
        bus8.ci    = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t4 done1", 32'(bus8.done), 32'd1);
        check("t4 sum1", 32'(bus8.sum), 32'h81);
        check("t4 co1", 32'(bus8.co), 32'd0);
        bus8.start = 1'b1;
        bus8.a     = 8'h01;
        bus8.b     = 8'h01;
        bus8.ci    = 1'b0;
        tick();
        bus8.start = 1'b0;
        check("t4 rerun busy", 32'(bus8.busy), 32'd1);
        check("t4 rerun no_done", 32'(bus8.done), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check("t4 sum1 held", 32'(bus8.sum), 32'h81);
            tick();
        end
        check("t4 still busy", 32'(bus8.busy), 32'd1);
        tick();
        check("t4 done2", 32'(bus8.done), 32'd1);
        check("t4 sum2", 32'(bus8.sum), 32'h02);
        check("t4 co2", 32'(bus8.co), 32'd0);
        tick();
        check("t4 idle", 32'(bus8.state), 32'd0);

        // Asynchronous reset mid-RUN, between edges; preload a nonzero result first
        run8("pre rst", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);
        bus8.start = 1'b1;
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.ci    = 1'b0;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5 rst busy", 32'(bus8.busy), 32'd0);
        check("t5 rst done", 32'(bus8.done), 32'd0);
        check("t5 rst sum", 32'(bus8.sum), 32'd0);
        check("t5 rst co", 32'(bus8.co), 32'd0);
        check("t5 rst state", 32'(bus8.state), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t5 idle after rst", 32'(bus8.state), 32'd0);
        run8("t5 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // WIDTH=1: full-adder truth table, done 2 edges after start
        for (int k = 0; k < 8; k++) begin
            logic [2:0] abc;
            abc        = 3'(k);
            bus1.start = 1'b1;
            bus1.a     = abc[2];
            bus1.b     = abc[1];
            bus1.ci    = abc[0];
            tick();
            bus1.start = 1'b0;
            check($sformatf("t6 %0d busy", k), 32'(bus1.busy), 32'd1);
            check($sformatf("t6 %0d no_done", k), 32'(bus1.done), 32'd0);
            tick();
            check($sformatf("t6 %0d done", k), 32'(bus1.done), 32'd1);
            check($sformatf("t6 %0d cosum", k), 32'({bus1.co, bus1.sum}), 32'(fa_tab[k]));
            tick();
            check($sformatf("t6 %0d idle", k), 32'(bus1.state), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
